// File: rtl/simple_merger.sv
// -----------------------------------------------------------------------------
// simple_merger
//
// Purpose:
//   Merges four independent, non-backpressured source streams into a single
//   registered output stream. Each source owns a small FIFO. A round-robin
//   arbiter pops one FIFO head per cycle into the output register whenever
//   that register is free. Words that arrive at a full FIFO are dropped, and
//   a sticky per-port overflow flag records the drop.
//
// Parameters:
//   DATA_WIDTH  width of every data port (default 32)
//   FIFO_DEPTH  entries per input FIFO; power of two, >= 2 (default 4)
//
// Ports:
//   clk          in   single clock, rising-edge active
//   resetn       in   asynchronous active-low reset
//   din0..din3   in   source data, one word per port
//   din_en0..3   in   source data-valid strobes (no backpressure)
//   dout         out  merged data word (registered)
//   dout_addr    out  index of the port dout came from (registered)
//   dout_valid   out  dout/dout_addr hold a valid word (registered)
//   dout_ready   in   downstream accepts the word when high with dout_valid
//   overflow     out  sticky per-port drop flags, bit N for port N
// -----------------------------------------------------------------------------
module simple_merger #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    input  logic                  din_en0,
    input  logic                  din_en1,
    input  logic                  din_en2,
    input  logic                  din_en3,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            dout_addr,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [3:0]            overflow
);

    localparam int NUM_PORTS = 4;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // -------------------------------------------------------------------------
    // Input bundling: index the four ports uniformly from here on.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] din_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]  din_en_vec;

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;
    assign din_arr[3] = din3;
    assign din_en_vec = {din_en3, din_en2, din_en1, din_en0};

    // -------------------------------------------------------------------------
    // FIFO state
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q    [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_PORTS];
    logic [CNT_W-1:0]      count_q  [NUM_PORTS];
    logic [CNT_W-1:0]      count_d  [NUM_PORTS];

    logic [NUM_PORTS-1:0]  fifo_full;
    logic [NUM_PORTS-1:0]  fifo_nonempty;
    logic [NUM_PORTS-1:0]  push;
    logic [NUM_PORTS-1:0]  pop;

    // -------------------------------------------------------------------------
    // Output / arbiter state
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] dout_q,       dout_d;
    logic [1:0]            dout_addr_q,  dout_addr_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [1:0]            last_grant_q, last_grant_d;
    logic [3:0]            overflow_q,   overflow_d;

    logic                  out_free;
    logic                  grant_found;
    logic [1:0]            grant_idx;
    logic                  do_grant;

    // -------------------------------------------------------------------------
    // FIFO status. Full/empty come from the occupancy before the edge, so a
    // word written this cycle is invisible to the arbiter until next cycle,
    // and a write into a full FIFO is dropped even if that FIFO pops now.
    // -------------------------------------------------------------------------
    // NOTE: every variable driven in an always_comb gets a value on every path
    // (defaults first) so no latch is inferred.
    always_comb begin
        fifo_full     = '0;
        fifo_nonempty = '0;
        push          = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            fifo_full[p]     = (count_q[p] == CNT_FULL);
            fifo_nonempty[p] = (count_q[p] != '0);
            push[p]          = din_en_vec[p] && !fifo_full[p];
        end
    end

    // Output register can take a new word when empty or being drained now.
    assign out_free = !dout_valid_q || dout_ready;

    // -------------------------------------------------------------------------
    // Round-robin arbiter: search from last_grant+1 upward with wrap; the
    // first non-empty FIFO wins.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = last_grant_q + 2'(i);
            if (!grant_found && fifo_nonempty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign do_grant = out_free && grant_found;

    always_comb begin
        pop = '0;
        if (do_grant) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointer and occupancy next state. Pointers wrap naturally because
    // FIFO_DEPTH is a power of two.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p];
            rd_ptr_d[p] = rd_ptr_q[p];
            count_d[p]  = count_q[p];

            if (push[p]) begin
                wr_ptr_d[p] = wr_ptr_q[p] + PTR_ONE;
            end
            if (pop[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + PTR_ONE;
            end

            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push[p], pop[p]})
                2'b10:   count_d[p] = count_q[p] + CNT_ONE;
                2'b01:   count_d[p] = count_q[p] - CNT_ONE;
                default: count_d[p] = count_q[p];
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output register, arbiter pointer and overflow next state. When the
    // output is stalled everything holds; when free with nothing to send only
    // dout_valid drops and the data/address keep their last values.
    // -------------------------------------------------------------------------
    always_comb begin
        dout_d       = dout_q;
        dout_addr_d  = dout_addr_q;
        dout_valid_d = dout_valid_q;
        last_grant_d = last_grant_q;

        if (do_grant) begin
            dout_d       = mem_q[grant_idx][rd_ptr_q[grant_idx]];
            dout_addr_d  = grant_idx;
            dout_valid_d = 1'b1;
            last_grant_d = grant_idx;
        end else if (out_free) begin
            dout_valid_d = 1'b0;
        end

        overflow_d = overflow_q | (din_en_vec & fifo_full);
    end

    // -------------------------------------------------------------------------
    // Control state registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
            dout_q       <= '0;
            dout_addr_q  <= '0;
            dout_valid_q <= 1'b0;
            last_grant_q <= 2'd3;   // port 0 searched first after reset
            overflow_q   <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                count_q[p]  <= count_d[p];
            end
            dout_q       <= dout_d;
            dout_addr_q  <= dout_addr_d;
            dout_valid_q <= dout_valid_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage.
    // -------------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; occupancy and
    // pointers are, so stale contents can never be read, and the array can
    // map onto plain flops or RAM without a reset network.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) begin
                mem_q[p][wr_ptr_q[p]] <= din_arr[p];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_addr  = dout_addr_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_simple_merger.sv
// -----------------------------------------------------------------------------
// tb_simple_merger
//
// Directed testbench for simple_merger (DATA_WIDTH=32, FIFO_DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_simple_merger;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] din0, din1, din2, din3;
    logic        din_en0, din_en1, din_en2, din_en3;
    logic [31:0] dout;
    logic [1:0]  dout_addr;
    logic        dout_valid;
    logic        dout_ready;
    logic [3:0]  overflow;

    int checks = 0;
    int errors = 0;

    simple_merger #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .din_en0    (din_en0),
        .din_en1    (din_en1),
        .din_en2    (din_en2),
        .din_en3    (din_en3),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        din_en0 = 1'b0;
        din_en1 = 1'b0;
        din_en2 = 1'b0;
        din_en3 = 1'b0;
    endtask

    task automatic drive(input int port, input logic [31:0] data);
        case (port)
            0: begin din_en0 = 1'b1; din0 = data; end
            1: begin din_en1 = 1'b1; din1 = data; end
            2: begin din_en2 = 1'b1; din2 = data; end
            default: begin din_en3 = 1'b1; din3 = data; end
        endcase
    endtask

    task automatic expect_word(input string tag, input logic [31:0] data, input logic [1:0] addr);
        check({tag, "_valid"}, 32'(dout_valid), 32'd1);
        check({tag, "_data"},  dout,            data);
        check({tag, "_addr"},  32'(dout_addr),  32'(addr));
    endtask

    initial begin
        resetn     = 1'b0;
        dout_ready = 1'b1;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        idle();

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_valid",    32'(dout_valid), 32'd0);
        check("rst_data",     dout,            32'd0);
        check("rst_addr",     32'(dout_addr),  32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        resetn = 1'b1;
        tick();
        check("idle_valid", 32'(dout_valid), 32'd0);

        // ---------------- single word, two-edge latency ----------------
        drive(2, 32'hA5A5_0001);
        tick();                                   // word written
        idle();
        check("single_no_bypass", 32'(dout_valid), 32'd0);
        tick();                                   // word popped to output
        expect_word("single", 32'hA5A5_0001, 2'd2);
        tick();
        check("single_one_cycle", 32'(dout_valid), 32'd0);
        check("single_data_hold", dout,            32'hA5A5_0001);
        check("single_addr_hold", 32'(dout_addr),  32'd2);

        // ---------------- fairness after fresh reset ----------------
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        drive(0, 32'h0000_0100);
        drive(1, 32'h0000_0101);
        drive(2, 32'h0000_0102);
        drive(3, 32'h0000_0103);
        tick();
        idle();
        check("fair_no_bypass", 32'(dout_valid), 32'd0);
        tick();
        expect_word("fair0", 32'h0000_0100, 2'd0);
        tick();
        expect_word("fair1", 32'h0000_0101, 2'd1);
        tick();
        expect_word("fair2", 32'h0000_0102, 2'd2);
        tick();
        expect_word("fair3", 32'h0000_0103, 2'd3);
        tick();
        check("fair_done", 32'(dout_valid), 32'd0);

        // ---------------- backpressure (last_grant is 3) ----------------
        dout_ready = 1'b0;
        drive(0, 32'h0000_00A0);
        drive(3, 32'h0000_00D0);
        tick();
        drive(0, 32'h0000_00A1);
        drive(3, 32'h0000_00D1);
        tick();                                   // A0 granted into output
        idle();
        for (int c = 0; c < 5; c++) begin
            expect_word("bp_hold", 32'h0000_00A0, 2'd0);
            tick();
        end
        expect_word("bp_hold_last", 32'h0000_00A0, 2'd0);
        dout_ready = 1'b1;
        tick();
        expect_word("bp_d0", 32'h0000_00D0, 2'd3);
        tick();
        expect_word("bp_a1", 32'h0000_00A1, 2'd0);
        tick();
        expect_word("bp_d1", 32'h0000_00D1, 2'd3);
        tick();
        check("bp_done", 32'(dout_valid), 32'd0);

        // ---------------- overflow on port 1 ----------------
        dout_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 32'h0000_0200 + 32'(k));
            tick();
            if (k == 4) begin
                check("ovf_before", 32'(overflow), 32'd0);
            end
        end
        idle();
        check("ovf_set", 32'(overflow), 32'b0010);
        expect_word("ovf_head", 32'h0000_0200, 2'd1);
        dout_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            expect_word("ovf_drain", 32'h0000_0200 + 32'(k), 2'd1);
        end
        tick();
        check("ovf_drain_done", 32'(dout_valid), 32'd0);
        check("ovf_sticky",     32'(overflow),   32'b0010);

        // ---------------- reset mid-drain ----------------
        dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(2, 32'h0000_0300 + 32'(k));
            tick();
        end
        idle();
        expect_word("rmd_head", 32'h0000_0300, 2'd2);
        resetn = 1'b0;
        #1;                                       // asynchronous: no edge needed
        check("rmd_async_valid",    32'(dout_valid), 32'd0);
        check("rmd_async_overflow", 32'(overflow),   32'd0);
        drive(0, 32'h0000_0BAD);                  // must be ignored in reset
        tick();
        idle();
        resetn     = 1'b1;
        dout_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rmd_quiet", 32'(dout_valid), 32'd0);
        end

        // ---------------- recovery after reset ----------------
        drive(1, 32'h0000_0777);
        tick();
        idle();
        tick();
        expect_word("recover", 32'h0000_0777, 2'd1);
        tick();
        check("recover_done", 32'(dout_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simple_merger.md
SIMPLE_MERGER -- requirements
Module: simple_merger

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every data port.
REQ-002 Parameter FIFO_DEPTH, default 4, entries per input FIFO; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 din0..din3  input  DATA_WIDTH each  data from source port 0..3.
REQ-006 din_en0..din_en3  input  1 each  data-valid strobe for port 0..3; no backpressure toward sources.
REQ-007 dout  output  DATA_WIDTH  merged data word, registered.
REQ-008 dout_addr  output  2  index of the port dout came from, registered.
REQ-009 dout_valid  output  1  dout/dout_addr hold a valid word, registered.
REQ-010 dout_ready  input  1  downstream accepts the word when high with dout_valid.
REQ-011 overflow  output  4  sticky per-port drop flag, bit N for port N.

Function
REQ-012 One FIFO per port, FIFO_DEPTH entries; write when din_enN high at a clk edge and FIFO N not full.
REQ-013 Full/empty decided from occupancy before the edge; write to a full FIFO dropped even if that FIFO pops on the same edge; overflow[N] set to 1 on that edge.
REQ-014 overflow[N] stays 1 until reset; no other clear.
REQ-015 Simultaneous write and pop on a non-full FIFO both take effect; occupancy unchanged.
REQ-016 Output register "free" when dout_valid==0 or (dout_valid && dout_ready).
REQ-017 When free and at least one FIFO non-empty: grant one port, pop its head into dout, write its index to dout_addr, set dout_valid=1, same edge.
REQ-018 When free and all FIFOs empty: dout_valid=0 next edge; dout/dout_addr hold last value.
REQ-019 When not free (dout_valid && !dout_ready): dout, dout_addr, dout_valid, arbiter pointer and all FIFO read pointers hold.
REQ-020 Arbitration round-robin: search starts at (last_grant+1) mod 4, ascending with wrap; first non-empty FIFO wins; last_grant updates only on a grant.
REQ-021 A word written at edge k is not visible to the arbiter before edge k+1; minimum din_enN-to-dout_valid latency 2 edges (no bypass).
REQ-022 Sustained throughput 1 word/cycle while dout_ready high and any FIFO non-empty.
REQ-023 Per-port ordering preserved; no word duplicated or lost except drops flagged per REQ-013.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.

Reset
REQ-025 resetn low asynchronously: dout_valid=0, dout=0, dout_addr=0, overflow=0, all FIFOs empty, last_grant=3 (port 0 highest priority first).
REQ-026 Reset mid-operation discards all buffered and in-flight words; no output activity until a new din_enN after resetn rises.
REQ-027 resetn deasserted synchronously to clk by the integrator; din_enN ignored while resetn low.

Verification
REQ-028 Single word: din_en2=1, din2=0xA5A5_0001 for one cycle, dout_ready=1 -> dout_valid=1 two edges later, dout=0xA5A5_0001, dout_addr=2, one cycle only.
REQ-029 Fairness: all four ports strobe once in the same cycle after reset, dout_ready=1 -> outputs on 4 consecutive cycles, dout_addr 0,1,2,3.
REQ-030 Backpressure: dout_ready=0 with dout_valid=1 for 5 cycles -> dout/dout_addr unchanged throughout; after dout_ready=1 remaining words drain in order, none lost.
REQ-031 Overflow: dout_ready=0, port 1 strobed 6 times, FIFO_DEPTH=4 -> overflow=4'b0010 from the 6th strobe (one word in output register, four buffered, 6th dropped); drain yields first 5 words in order; overflow stays 1.
REQ-032 Reset mid-drain: resetn low with 3 words buffered -> dout_valid=0, overflow=0 immediately; after release no dout_valid without new input.
